// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR configuration slave.
package fir_pkg;

  localparam int unsigned ADDR_AP_CTRL  = 32'h00;
  localparam int unsigned ADDR_DATA_LEN = 32'h10;
  localparam int unsigned ADDR_TAP_BASE = 32'h20;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/fir_axil_wr_join.sv
// Joins independently accepted AXI-Lite AW and W beats into one write strobe.
module fir_axil_wr_join #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  output logic              wr_en_c,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  // ready low means the channel's holding register is occupied
  assign wr_en_c = !awready && !wready;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      awready <= 1'b1;
      wready  <= 1'b1;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (wr_en_c) begin
      awready <= 1'b1;
      wready  <= 1'b1;
    end else begin
      if (awvalid && awready) begin
        wr_addr <= awaddr;
        awready <= 1'b0;
      end
      if (wvalid && wready) begin
        wr_data <= wdata;
        wready  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_cfg_slave.sv
// AXI-Lite configuration responder for the FIR core: ap_ctrl handshake,
// data_length and tap coefficient storage.
module fir_cfg_slave
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pTAP_NUM    = 11
) (
  input  logic                         axis_clk,
  input  logic                         axis_rst_n,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [pADDR_WIDTH-1:0]       awaddr,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic [pDATA_WIDTH-1:0]       wdata,
  input  logic                         arvalid,
  output logic                         arready,
  input  logic [pADDR_WIDTH-1:0]       araddr,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [pDATA_WIDTH-1:0]       rdata,
  output logic                         core_start,
  input  logic                         core_done,
  output logic [31:0]                  data_length,
  input  logic [$clog2(pTAP_NUM)-1:0]  tap_idx,
  output logic [pDATA_WIDTH-1:0]       tap_data
);

  localparam int unsigned TAP_IW = $clog2(pTAP_NUM);
  localparam logic [pADDR_WIDTH-1:0] A_CTRL     = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_LEN      = pADDR_WIDTH'(ADDR_DATA_LEN);
  localparam logic [pADDR_WIDTH-1:0] A_TAP      = pADDR_WIDTH'(ADDR_TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_SPAN = pADDR_WIDTH'(4 * pTAP_NUM);

  logic                   wr_en_c;
  logic [pADDR_WIDTH-1:0] wr_addr;
  logic [pDATA_WIDTH-1:0] wr_data;
  logic [pADDR_WIDTH-1:0] ar_addr;
  logic [pDATA_WIDTH-1:0] rd_val_c;
  logic [pDATA_WIDTH-1:0] taps [pTAP_NUM];
  ctrl_state_e            state_q, state_d;
  logic                   ap_done;
  logic                   start_req_c;
  logic                   cfg_wr_ok_c;

  fir_axil_wr_join #(
    .ADDR_W (pADDR_WIDTH),
    .DATA_W (pDATA_WIDTH)
  ) u_wr_join (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wr_en_c    (wr_en_c),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // Word-aligned address inside the tap window
  function automatic logic tap_hit(input logic [pADDR_WIDTH-1:0] a);
    logic [pADDR_WIDTH-1:0] off;
    off = a - A_TAP;
    return (a >= A_TAP) && (off < A_TAP_SPAN) && (off[1:0] == 2'b00);
  endfunction

  function automatic logic [TAP_IW-1:0] tap_sel(input logic [pADDR_WIDTH-1:0] a);
    logic [pADDR_WIDTH-1:0] off;
    off = a - A_TAP;
    return off[TAP_IW+1:2];
  endfunction

  assign start_req_c = wr_en_c && (wr_addr == A_CTRL) && wr_data[AP_START_BIT];
  assign cfg_wr_ok_c = wr_en_c && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_req_c) state_d = START;
      START:   state_d = RUN;
      RUN:     if (core_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q    <= IDLE;
      core_start <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_start <= (state_d == START);
    end
  end

  // Completion from the core outranks a clearing read of ap_ctrl
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ap_done <= 1'b0;
    end else if ((state_q == RUN) && core_done) begin
      ap_done <= 1'b1;
    end else if ((state_q == IDLE) && (state_d == START)) begin
      ap_done <= 1'b0;
    end else if (rvalid && rready && (ar_addr == A_CTRL)) begin
      ap_done <= 1'b0;
    end
  end

  // Configuration is frozen while the core is running
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      data_length <= '0;
      for (int i = 0; i < int'(pTAP_NUM); i++) taps[i] <= '0;
    end else if (cfg_wr_ok_c) begin
      if (wr_addr == A_LEN) data_length <= 32'(wr_data);
      if (tap_hit(wr_addr)) taps[tap_sel(wr_addr)] <= wr_data;
    end
  end

  always_comb begin
    rd_val_c = '0;
    if (araddr == A_CTRL) begin
      rd_val_c[AP_START_BIT] = (state_q == START);
      rd_val_c[AP_DONE_BIT]  = ap_done;
      rd_val_c[AP_IDLE_BIT]  = (state_q == IDLE);
    end else if (araddr == A_LEN) begin
      rd_val_c = pDATA_WIDTH'(data_length);
    end else if (tap_hit(araddr)) begin
      rd_val_c = taps[tap_sel(araddr)];
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      ar_addr <= '0;
    end else if (arvalid && arready) begin
      ar_addr <= araddr;
      arready <= 1'b0;
      rvalid  <= 1'b1;
      rdata   <= rd_val_c;
    end else if (rvalid && rready) begin
      rvalid  <= 1'b0;
      arready <= 1'b1;
    end
  end

  assign tap_data = (32'(tap_idx) < pTAP_NUM) ? taps[tap_idx] : '0;

endmodule

// File: tb/tb_fir_cfg_slave.sv
// Scoreboard bench for fir_cfg_slave: reads queue expectations, a monitor checks them.
module tb_fir_cfg_slave;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b1;
  logic        awready, wready, arready, rvalid;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        core_start, core_done = 1'b0;
  logic [31:0] data_length;
  logic [3:0]  tap_idx = '0;
  logic [31:0] tap_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mask_q [$];
  string       name_q [$];

  int tap_v [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  fir_cfg_slave dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .core_start  (core_start),
    .core_done   (core_done),
    .data_length (data_length),
    .tap_idx     (tap_idx),
    .tap_data    (tap_data)
  );

  always #5 axis_clk = ~axis_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out got 0x0 want 0x1", nm);
  endtask

  // Monitor: every completed read beat is compared against the oldest expectation
  initial begin
    forever begin
      @(negedge axis_clk);
      if (axis_rst_n && rvalid && rready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_read: got 0x%0h want no read", rdata);
        end else begin
          logic [31:0] e, m;
          string nm;
          e = exp_q.pop_front();
          m = mask_q.pop_front();
          nm = name_q.pop_front();
          if ((rdata & m) !== (e & m)) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, rdata & m, e & m);
          end
        end
      end
    end
  end

  task automatic expect_rd(input logic [31:0] e, input logic [31:0] m, input string nm);
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    bit aw_done = 0, w_done = 0;
    int t = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done)) begin
      @(negedge axis_clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge axis_clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      if (++t > 20) begin
        timeout_fail("write_handshake");
        awvalid = 1'b0; wvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic ar_handshake(input logic [11:0] a);
    bit ok = 0;
    int t = 0;
    araddr = a; arvalid = 1'b1;
    while (!ok) begin
      @(negedge axis_clk);
      ok = arready;
      @(posedge axis_clk); #1;
      if (++t > 20) begin
        timeout_fail("ar_handshake");
        break;
      end
    end
    arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] e,
                          input logic [31:0] m, input string nm);
    bit done = 0;
    int t = 0;
    expect_rd(e, m, nm);
    ar_handshake(a);
    while (!done) begin
      @(negedge axis_clk);
      done = rvalid && rready;
      @(posedge axis_clk); #1;
      if (++t > 20) begin
        timeout_fail("r_handshake");
        break;
      end
    end
  endtask

  initial begin
    int cnt;
    // Reset state
    repeat (3) @(posedge axis_clk);
    #1;
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_data_length", data_length, 32'd0);
    @(negedge axis_clk) axis_rst_n = 1'b1;
    @(posedge axis_clk); #1;
    axi_read(12'h000, 32'h4, 32'hFFFF_FFFF, "ctrl_after_reset");

    // Configuration writes and readback
    axi_write(12'h010, 32'd600);
    for (int k = 0; k < 11; k++) axi_write(12'(32'h20 + 4 * k), 32'(tap_v[k]));
    axi_read(12'h010, 32'd600, 32'hFFFF_FFFF, "rd_data_length");
    for (int k = 0; k < 11; k++)
      axi_read(12'(32'h20 + 4 * k), 32'(tap_v[k]), 32'hFFFF_FFFF, $sformatf("rd_tap%0d", k));
    axi_read(12'h04C, 32'h0, 32'hFFFF_FFFF, "rd_unmapped");
    tap_idx = 4'd5;
    #1 check("tap_data_idx5", tap_data, 32'd63);
    check("data_length_port", data_length, 32'd600);

    // W presented two cycles before AW
    wdata = 32'd77; wvalid = 1'b1;
    @(negedge axis_clk);
    @(posedge axis_clk); #1 wvalid = 1'b0;
    @(negedge axis_clk);
    check("wfirst_wready_low", 32'(wready), 32'd0);
    check("wfirst_awready_high", 32'(awready), 32'd1);
    @(posedge axis_clk); #1;
    @(negedge axis_clk);
    check("wfirst_wready_held", 32'(wready), 32'd0);
    @(posedge axis_clk); #1 awaddr = 12'h048; awvalid = 1'b1;
    @(posedge axis_clk); #1 awvalid = 1'b0;
    @(negedge axis_clk);
    check("join_awready_low", 32'(awready), 32'd0);
    check("join_wready_low", 32'(wready), 32'd0);
    @(posedge axis_clk); #1;
    @(negedge axis_clk);
    check("join_awready_back", 32'(awready), 32'd1);
    check("join_wready_back", 32'(wready), 32'd1);
    @(posedge axis_clk); #1;
    axi_read(12'h048, 32'd77, 32'hFFFF_FFFF, "rd_tap10_wfirst");
    axi_write(12'h048, 32'd0);
    @(negedge axis_clk);
    check("same_cycle_ready_low", 32'({awready, wready}), 32'd0);
    @(posedge axis_clk); #1;
    axi_read(12'h048, 32'd0, 32'hFFFF_FFFF, "rd_tap10_same_cycle");

    // rready stall on a read of tap 1
    rready = 1'b0;
    expect_rd(32'hFFFF_FFF6, 32'hFFFF_FFFF, "rd_tap1_stalled");
    ar_handshake(12'h024);
    for (int i = 0; i < 3; i++) begin
      @(negedge axis_clk);
      check("stall_rvalid", 32'(rvalid), 32'd1);
      check("stall_rdata", rdata, 32'hFFFF_FFF6);
      check("stall_arready", 32'(arready), 32'd0);
      @(posedge axis_clk); #1;
    end
    rready = 1'b1;
    @(posedge axis_clk); #1;
    @(negedge axis_clk);
    check("stall_arready_back", 32'(arready), 32'd1);
    @(posedge axis_clk); #1;

    // Start pulse, RUN status, configuration lockout
    axi_write(12'h000, 32'h1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge axis_clk);
      if (core_start) cnt++;
    end
    check("core_start_pulse_count", 32'(cnt), 32'd1);
    @(posedge axis_clk); #1;
    axi_read(12'h000, 32'h0, 32'hF, "ctrl_in_run");
    axi_write(12'h010, 32'd5);
    @(posedge axis_clk); #1;
    axi_read(12'h010, 32'd600, 32'hFFFF_FFFF, "len_locked_rd");
    check("len_locked_port", data_length, 32'd600);
    axi_write(12'h000, 32'h1);
    @(posedge axis_clk); #1;
    axi_read(12'h000, 32'h0, 32'hF, "start_in_run_ignored");

    // core_done -> done+idle, read clears done
    core_done = 1'b1;
    @(posedge axis_clk); #1 core_done = 1'b0;
    axi_read(12'h000, 32'h6, 32'hFFFF_FFFF, "ctrl_done");
    axi_read(12'h000, 32'h4, 32'hFFFF_FFFF, "ctrl_done_cleared");

    // Clearing read completes in the same cycle as core_done
    axi_write(12'h000, 32'h1);
    repeat (4) @(posedge axis_clk);
    #1 rready = 1'b0;
    expect_rd(32'h0, 32'hF, "ctrl_run_before_done");
    ar_handshake(12'h000);
    rready = 1'b1; core_done = 1'b1;
    @(posedge axis_clk); #1 core_done = 1'b0;
    axi_read(12'h000, 32'h6, 32'hFFFF_FFFF, "done_wins_over_clear");
    axi_read(12'h000, 32'h4, 32'hFFFF_FFFF, "done_then_cleared");

    // Reset with AW held and a read pending
    rready = 1'b0;
    awaddr = 12'h020; awvalid = 1'b1; wvalid = 1'b0;
    araddr = 12'h010; arvalid = 1'b1;
    @(posedge axis_clk); #1 awvalid = 1'b0; arvalid = 1'b0;
    @(negedge axis_clk);
    check("pre_rst_aw_held", 32'(awready), 32'd0);
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #2 axis_rst_n = 1'b0;
    #1;
    check("mid_rst_awready", 32'(awready), 32'd1);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd1);
    check("mid_rst_data_length", data_length, 32'd0);
    check("mid_rst_tap_data", tap_data, 32'd0);
    @(negedge axis_clk) axis_rst_n = 1'b1;
    rready = 1'b1;
    @(posedge axis_clk); #1;
    axi_read(12'h010, 32'h0, 32'hFFFF_FFFF, "post_rst_len");
    for (int k = 0; k < 11; k++)
      axi_read(12'(32'h20 + 4 * k), 32'h0, 32'hFFFF_FFFF, $sformatf("post_rst_tap%0d", k));

    repeat (3) @(posedge axis_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
